multicycle_main_control: RTL and testbench

//  Main sequencer for the multicycle MIPS datapath: walks each instruction through fetch/decode/execute/mem/writeback.

---
 rtl/mips_ctrl_pkg.sv | 64 ++++++
 rtl/ctrl_output_decode.sv | 79 +++++++
 rtl/multicycle_main_control.sv | 113 +++++++++++
 tb/tb_multicycle_main_control.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller, ALUControl and datapath:
// opcodes, sequencer states, ALUOpcode, alu_src_b and pc_source codes.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

  function automatic logic is_supported_op(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Combinational control-word decode from the current sequencer state.
// FETCH and BRANCH are Mealy: IR/PC writes depend on mem_ready and zero.
module ctrl_output_decode
  import mips_ctrl_pkg::*;
(
  input  state_e      state,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output ctrl_t       ctrl
);

  // Control word per state; anything not set stays 0.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALU_ADD;
        ctrl.illegal   = ~is_supported_op(opcode);
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_source = PCSRC_ALUOUT;
        ctrl.pc_write  = (opcode == OP_BNE) ? ~zero : zero;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.pc_write  = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_main_control.sv
// Main sequencer for the multicycle MIPS datapath.
//
//  state    | meaning
//  FETCH    | read instruction at PC, PC+4; waits on mem_ready
//  DECODE   | branch target precompute, dispatch on opcode
//  MEMADR   | effective address for lw/sw
//  MEMRD    | data read; waits on mem_ready
//  MEMWB    | MDR -> rt
//  MEMWR    | data write; waits on mem_ready
//  EXEC     | R-type ALU op
//  ALUWB    | ALUOut -> rd
//  BRANCH   | compare, conditional PC load
//  ADDIEX   | A + sign-ext imm
//  ADDIWB   | ALUOut -> rt
//  JUMP     | PC <- jump target
module multicycle_main_control
  import mips_ctrl_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] ALUOpcode,
  output logic [1:0] pc_source,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  state_e state_q;
  state_e state_d;
  logic   mem_rdy_eff;
  ctrl_t  ctrl;

  assign mem_rdy_eff = MEM_HANDSHAKE ? mem_ready : 1'b1;

  ctrl_output_decode u_decode (
    .state     (state_q),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_rdy_eff),
    .ctrl      (ctrl)
  );

  // Next-state: walk the instruction through its phases, stalling on memory.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_rdy_eff) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_RTYPE:       state_d = S_EXEC;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI:        state_d = S_ADDIEX;
          OP_J:           state_d = S_JUMP;
          default:        state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LW)      state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD:  if (mem_rdy_eff) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_rdy_eff) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // State register; reset parks the sequencer in FETCH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  // Enables are gated by rst directly so an in-flight write dies the moment
  // reset asserts; selects already show FETCH values since state is FETCH.
  assign pc_write   = ctrl.pc_write  & rst;
  assign mem_read   = ctrl.mem_read  & rst;
  assign mem_write  = ctrl.mem_write & rst;
  assign ir_write   = ctrl.ir_write  & rst;
  assign reg_write  = ctrl.reg_write & rst;
  assign illegal    = ctrl.illegal   & rst;
  assign i_or_d     = ctrl.i_or_d;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_dst    = ctrl.reg_dst;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign ALUOpcode  = ctrl.alu_op;
  assign pc_source  = ctrl.pc_source;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Self-checking bench: random instruction streams against a per-instruction
// phase model, plus reset and no-handshake scenarios.
module tb_multicycle_main_control;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mr_tied = 1'b0;

  logic       pcw1, iord1, mr1, mw1, irw1, m2r1, rd1, rw1, asa1, ill1;
  logic [1:0] asb1, aop1, pcs1;
  logic [3:0] st1;
  logic       pcw2, iord2, mr2, mw2, irw2, m2r2, rd2, rw2, asa2, ill2;
  logic [1:0] asb2, aop2, pcs2;
  logic [3:0] st2;

  int n_chk  = 0;
  int n_pass = 0;
  bit sel    = 1'b0;   // 0: checking handshake DUT, 1: no-handshake DUT
  logic [5:0] cur_op = 6'd0;

  always #5 clk = ~clk;

  multicycle_main_control #(.MEM_HANDSHAKE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pcw1), .i_or_d(iord1), .mem_read(mr1), .mem_write(mw1),
    .ir_write(irw1), .mem_to_reg(m2r1), .reg_dst(rd1), .reg_write(rw1),
    .alu_src_a(asa1), .alu_src_b(asb1), .ALUOpcode(aop1), .pc_source(pcs1),
    .illegal(ill1), .state_dbg(st1)
  );

  multicycle_main_control #(.MEM_HANDSHAKE(1'b0)) dut2 (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mr_tied),
    .pc_write(pcw2), .i_or_d(iord2), .mem_read(mr2), .mem_write(mw2),
    .ir_write(irw2), .mem_to_reg(m2r2), .reg_dst(rd2), .reg_write(rw2),
    .alu_src_a(asa2), .alu_src_b(asb2), .ALUOpcode(aop2), .pc_source(pcs2),
    .illegal(ill2), .state_dbg(st2)
  );

  wire [15:0] obs1 = {pcw1, iord1, mr1, mw1, irw1, m2r1, rd1, rw1, asa1, asb1, aop1, pcs1, ill1};
  wire [15:0] obs2 = {pcw2, iord2, mr2, mw2, irw2, m2r2, rd2, rw2, asa2, asb2, aop2, pcs2, ill2};
  wire [15:0] obs_ctrl = sel ? obs2 : obs1;
  wire [3:0]  obs_st   = sel ? st2 : st1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Control word layout: pcw iord mr mw irw m2r rd rw asa asb[2] aop[2] pcs[2] ill
  function automatic logic [15:0] cw(input logic pcw, input logic iord, input logic mrd,
                                     input logic mwr, input logic irw, input logic m2r,
                                     input logic rdst, input logic rwr, input logic asa,
                                     input logic [1:0] asb, input logic [1:0] aop,
                                     input logic [1:0] pcs, input logic ill);
    return {pcw, iord, mrd, mwr, irw, m2r, rdst, rwr, asa, asb, aop, pcs, ill};
  endfunction

  task automatic do_cycle(input string tag, input int st, input logic [15:0] exp,
                          input logic mr, input logic z);
    @(negedge clk);
    rst = 1'b1;
    mem_ready = mr;
    zero = z;
    opcode = cur_op;
    #1;
    check({tag, ".state"}, {28'd0, obs_st}, st);
    check({tag, ".ctrl"}, {16'd0, obs_ctrl}, {16'd0, exp});
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".state"}, {28'd0, obs_st}, 0);
    check({tag, ".ctrl"}, {16'd0, obs_ctrl},
          {16'd0, cw(0,0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0)});
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // One instruction: fetch with fs stall cycles, memory phase with ms stalls.
  task automatic run_instr(input logic [5:0] op, input logic z, input int fs, input int ms);
    bit legal;
    legal = (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
            (op == 6'b000100) || (op == 6'b000101) || (op == 6'b001000) ||
            (op == 6'b000010);
    for (int i = 0; i < fs; i++)
      do_cycle("fetch_wait", 0, cw(0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0), 1'b0, rb());
    do_cycle("fetch", 0, cw(1,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0), 1'b1, rb());
    cur_op = op;
    do_cycle("decode", 1, cw(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,!legal), rb(), rb());
    case (op)
      6'b100011: begin
        do_cycle("lw_adr", 2, cw(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), rb(), rb());
        for (int i = 0; i < ms; i++)
          do_cycle("lw_rd_wait", 3, cw(0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0), 1'b0, rb());
        do_cycle("lw_rd", 3, cw(0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0), 1'b1, rb());
        do_cycle("lw_wb", 4, cw(0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0), rb(), rb());
      end
      6'b101011: begin
        do_cycle("sw_adr", 2, cw(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), rb(), rb());
        for (int i = 0; i < ms; i++)
          do_cycle("sw_wr_wait", 5, cw(0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0), 1'b0, rb());
        do_cycle("sw_wr", 5, cw(0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0), 1'b1, rb());
      end
      6'b000000: begin
        do_cycle("r_exec", 6, cw(0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0), rb(), rb());
        do_cycle("r_wb", 7, cw(0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0), rb(), rb());
      end
      6'b000100, 6'b000101: begin
        do_cycle("branch", 8,
                 cw((op == 6'b000100) ? z : !z,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0), rb(), z);
      end
      6'b001000: begin
        do_cycle("addi_ex", 9, cw(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), rb(), rb());
        do_cycle("addi_wb", 10, cw(0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0), rb(), rb());
      end
      6'b000010: begin
        do_cycle("jump", 11, cw(1,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0), rb(), rb());
      end
      default: ;
    endcase
  endtask

  function automatic logic [5:0] rand_op();
    logic [5:0] ops [7];
    int k;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b001000, 6'b000010};
    k = $urandom_range(0, 7);
    if (k == 7) return 6'($urandom_range(0, 63));
    return ops[k];
  endfunction

  initial begin
    // power-up reset
    sel = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_reset("por");

    // directed sequences on the handshake DUT
    run_instr(6'b000000, 1'b0, 0, 0);
    run_instr(6'b100011, 1'b0, 0, 2);
    run_instr(6'b000100, 1'b1, 0, 0);
    run_instr(6'b000101, 1'b1, 0, 0);
    run_instr(6'b000100, 1'b0, 1, 0);
    run_instr(6'b111111, 1'b0, 0, 0);
    run_instr(6'b001000, 1'b0, 2, 0);

    // reset while a store is stalled in MEMWR
    do_cycle("rs_fetch", 0, cw(1,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0), 1'b1, 1'b0);
    cur_op = 6'b101011;
    do_cycle("rs_decode", 1, cw(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0), 1'b0, 1'b0);
    do_cycle("rs_adr", 2, cw(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), 1'b0, 1'b0);
    do_cycle("rs_wr_wait", 5, cw(0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0), 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset("rst_mid_memwr");
    mem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    check_reset("rst_held");

    // random stream
    for (int n = 0; n < 60; n++)
      run_instr(rand_op(), rb(), $urandom_range(0, 2), $urandom_range(0, 3));

    // no-handshake DUT: mem_ready tied low, no stall cycles ever
    @(negedge clk);
    rst = 1'b0;
    sel = 1'b1;
    #1;
    check_reset("nohs_rst");
    @(posedge clk);
    run_instr(6'b101011, 1'b0, 0, 0);
    run_instr(6'b000010, 1'b0, 0, 0);
    for (int n = 0; n < 20; n++)
      run_instr(rand_op(), rb(), 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
